// File: rtl/datapath_seq_pkg.sv
// Shared encodings for the sequenced datapath: ALU/shift/writeback codes,
// FSM states and status-bit positions.
package datapath_seq_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    SRC_C     = 2'b00,
    SRC_IMM   = 2'b01,
    SRC_MDATA = 2'b10,
    SRC_PC    = 2'b11
  } src_sel_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXE  = 3'd3,
    S_WB   = 3'd4
  } state_e;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_V = 2;

endpackage

// File: rtl/dp_regfile.sv
// General register file: one combinational read port, one synchronous
// write port, all registers cleared by a synchronous reset.
module dp_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] regs [NREGS];

  // Reset wins over a pending write so an aborted operation never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/datapath_seq.sv
// Sequenced datapath: one request per handshake walks IDLE->RDA->RDB->EXE->WB,
// reading operands, running shifter+ALU into C/status and writing back.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_W  = 9,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    rn,
  input  logic [AW-1:0]    rm,
  input  logic [AW-1:0]    rd,
  input  logic [1:0]       alu_op,
  input  logic [1:0]       shift,
  input  logic             asel,
  input  logic             bsel,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       src_sel,
  input  logic             wb_en,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PC_W-1:0]  pc,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  output logic             done
);

  state_e state, state_next;

  logic [AW-1:0]    op_rn, op_rm, op_rd;
  alu_op_e          op_alu;
  shift_e           op_shift;
  src_sel_e         op_src;
  logic             op_asel, op_bsel, op_wb_en, op_set_flags;
  logic [WIDTH-1:0] op_imm;

  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic [2:0]       status_reg;

  logic [AW-1:0]    read_addr;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] b_shift, ain, bin, alu_out;
  logic             alu_v;
  logic [WIDTH-1:0] wb_data;
  logic             wb_we;
  logic             handshake;

  assign req_ready = (state == S_IDLE);
  assign done      = (state == S_WB);
  assign handshake = req_valid & req_ready;
  assign result    = c_reg;
  assign status    = status_reg;

  // State register for the operation sequencer.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Fixed five-step walk; only IDLE waits on the requester.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (handshake) state_next = S_RDA;
      S_RDA:   state_next = S_RDB;
      S_RDB:   state_next = S_EXE;
      S_EXE:   state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Latch the whole request on the handshake so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_rn        <= '0;
      op_rm        <= '0;
      op_rd        <= '0;
      op_alu       <= ALU_ADD;
      op_shift     <= SH_NONE;
      op_src       <= SRC_C;
      op_asel      <= 1'b0;
      op_bsel      <= 1'b0;
      op_wb_en     <= 1'b0;
      op_set_flags <= 1'b0;
      op_imm       <= '0;
    end else if (handshake) begin
      op_rn        <= rn;
      op_rm        <= rm;
      op_rd        <= rd;
      op_alu       <= alu_op_e'(alu_op);
      op_shift     <= shift_e'(shift);
      op_src       <= src_sel_e'(src_sel);
      op_asel      <= asel;
      op_bsel      <= bsel;
      op_wb_en     <= wb_en;
      op_set_flags <= set_flags;
      op_imm       <= imm;
    end
  end

  assign read_addr = (state == S_RDB) ? op_rm : op_rn;

  // Operand registers share the single read port across RDA and RDB.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (state == S_RDA) a_reg <= read_data;
      if (state == S_RDB) b_reg <= read_data;
    end
  end

  // Shifter on B, operand selection and ALU with signed-overflow detection.
  always_comb begin
    b_shift = b_reg;
    case (op_shift)
      SH_LSL1: b_shift = {b_reg[WIDTH-2:0], 1'b0};
      SH_LSR1: b_shift = {1'b0, b_reg[WIDTH-1:1]};
      SH_ASR1: b_shift = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
      default: b_shift = b_reg;
    endcase
    ain     = op_asel ? '0 : a_reg;
    bin     = op_bsel ? op_imm : b_shift;
    alu_out = '0;
    alu_v   = 1'b0;
    case (op_alu)
      ALU_ADD: begin
        alu_out = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_out = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_AND:  alu_out = ain & bin;
      ALU_NOTB: alu_out = ~bin;
      default:  alu_out = '0;
    endcase
  end

  // C and status are loaded only in EXE and otherwise hold between operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_reg      <= '0;
      status_reg <= '0;
    end else if (state == S_EXE) begin
      c_reg <= alu_out;
      if (op_set_flags) begin
        status_reg[STAT_Z] <= (alu_out == '0);
        status_reg[STAT_N] <= alu_out[WIDTH-1];
        status_reg[STAT_V] <= alu_v;
      end
    end
  end

  // Writeback source; C already holds this operation's ALU result in WB.
  always_comb begin
    wb_data = c_reg;
    case (op_src)
      SRC_C:     wb_data = c_reg;
      SRC_IMM:   wb_data = op_imm;
      SRC_MDATA: wb_data = mdata;
      SRC_PC:    wb_data = WIDTH'(pc);
      default:   wb_data = c_reg;
    endcase
  end

  assign wb_we = (state == S_WB) && op_wb_en;

  dp_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (wb_we),
    .waddr (op_rd),
    .wdata (wb_data),
    .raddr (read_addr),
    .rdata (read_data)
  );

endmodule
